fetch_ctrl: RTL

- Sequencer for the fetch-stage PC register and the IF/ID and ID/EX pipeline registers in the cached RV32I pipeline.
- Generates the PC write enable and the next-PC value.
- Runs the instruction-cache refill handshake and holds a branch/jump redirect that arrives during a stall.
- Issues stall and flush controls to the front-end pipeline registers.
- Counts refill-stall cycles for performance measurement.

---
 rtl/fetch_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Front-end sequencer: PC write enable / next-PC select, icache refill handshake,
// pending-redirect capture across stalls, and a saturating refill-stall counter.
module fetch_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ic_hit,
  output logic             ic_refill_req,
  input  logic             ic_refill_ack,
  input  logic             dc_stall,
  input  logic             load_use,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             dbg_state,
  output logic             dbg_pend_valid
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MISS = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_refill_req;
  logic             r_pend_valid;
  logic [WIDTH-1:0] r_pend_pc;
  logic [CNT_W-1:0] r_miss_cnt;

  logic             w_redir;
  logic [WIDTH-1:0] w_target;
  logic             w_run;
  logic             w_apply;
  logic             w_miss_enter;
  logic             w_cnt_sat;

  // A live redirect always beats an older pending one.
  assign w_redir      = redirect_valid | r_pend_valid;
  assign w_target     = redirect_valid ? redirect_pc : r_pend_pc;
  assign w_run        = (r_state == ST_RUN);
  assign w_apply      = w_run & ~dc_stall & w_redir;
  assign w_miss_enter = w_run & ~dc_stall & ~w_redir & ~ic_hit;
  assign w_cnt_sat    = &r_miss_cnt;

  // Refill handshake: ic_refill_req is a level raised on entry to MISS and
  // held until the single-cycle ic_refill_ack; ack outside MISS is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_refill_req <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_miss_enter) begin
            r_state      <= ST_MISS;
            r_refill_req <= 1'b1;
          end
        end
        ST_MISS: begin
          if (!w_cnt_sat) begin
            r_miss_cnt <= r_miss_cnt + 1'b1;
          end
          if (ic_refill_ack) begin
            r_state      <= ST_RUN;
            r_refill_req <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_RUN;
          r_refill_req <= 1'b0;
        end
      endcase

      if (w_apply) begin
        r_pend_valid <= 1'b0;
      end else if (redirect_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_pc    <= redirect_pc;
      end
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pc_next     = pc_plus4;
    if (rst && !dc_stall) begin
      if (!w_run) begin
        if_id_flush = 1'b1;
      end else if (w_redir) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        pc_next     = w_target;
      end else if (!ic_hit) begin
        if_id_flush = 1'b1;
      end else if (load_use) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
      end
    end
  end

  assign ic_refill_req  = r_refill_req;
  assign miss_cnt       = r_miss_cnt;
  assign dbg_state      = r_state;
  assign dbg_pend_valid = r_pend_valid;

endmodule
